batch_error_sequencer: RTL and testbench

BATCH_ERROR_SEQUENCER -- requirements
Module: batch_error_sequencer

---
 rtl/learning_pkg.sv | 27 ++
 rtl/error_accumulator.sv | 72 +++++++
 rtl/batch_error_sequencer.sv | 160 ++++++++++++++++
 tb/tb_batch_error_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/learning_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : learning_pkg
//  Description : Shared types and defaults for the batch error sequencer.
//                Holds the sequencer state encoding, the default batch size
//                and hold length, and the internal counter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package learning_pkg;

    // Default samples per weight update and hold length before the strobe.
    localparam int unsigned C_BATCH_DEFAULT       = 8;
    localparam int unsigned C_HOLD_CYCLES_DEFAULT = 2;

    // Sample counter must hold BATCH up to 256; hold counter covers 1..15.
    localparam int unsigned C_COUNT_W = 9;
    localparam int unsigned C_HOLD_W  = 4;

    typedef enum logic [1:0] {
        BE_IDLE   = 2'd0,
        BE_ACCUM  = 2'd1,
        BE_HOLD   = 2'd2,
        BE_STROBE = 2'd3
    } be_state_t;

endpackage : learning_pkg
`default_nettype wire

// File: rtl/error_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : error_accumulator
//  Description : Running sum of error, sum of squared error and sample count
//                for one batch. The next-state values are exported so the
//                closing edge can capture a total that already includes the
//                sample accepted on that same edge.
//  Ports       : clk_i        - clock, rising edge
//                rst_ni       - asynchronous active-low reset
//                clear_i      - restart the accumulation
//                add_i        - fold err_i into the running totals
//                err_i        - per-sample error
//                acc_nxt_o    - sum of error after this edge
//                sq_nxt_o     - sum of squared error after this edge
//                count_nxt_o  - sample count after this edge
//  Revision    : 1.0  initial release
// ============================================================================
module error_accumulator
    import learning_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 add_i,
    input  real                  err_i,
    output real                  acc_nxt_o,
    output real                  sq_nxt_o,
    output logic [C_COUNT_W-1:0] count_nxt_o
);

    real                  acc_q;
    real                  acc_d;
    real                  sq_q;
    real                  sq_d;
    logic [C_COUNT_W-1:0] count_q;
    logic [C_COUNT_W-1:0] count_d;

    // Clear is applied before add so clear+add loads the first sample.
    always_comb begin
        acc_d   = acc_q;
        sq_d    = sq_q;
        count_d = count_q;
        if (clear_i) begin
            acc_d   = 0.0;
            sq_d    = 0.0;
            count_d = '0;
        end
        if (add_i) begin
            acc_d   = acc_d + err_i;
            sq_d    = sq_d + (err_i * err_i);
            count_d = count_d + C_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= 0.0;
            sq_q    <= 0.0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            count_q <= count_d;
        end
    end

    assign acc_nxt_o   = acc_d;
    assign sq_nxt_o    = sq_d;
    assign count_nxt_o = count_d;

endmodule : error_accumulator
`default_nettype wire

// File: rtl/batch_error_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : batch_error_sequencer
//  Description : Collects per-sample errors (target - axon) into batches of
//                BATCH samples (or fewer on flush), publishes the mean error,
//                the sum of squared error and the latched training ratio,
//                holds them stable for HOLD_CYCLES cycles and then pulses
//                be_update for one cycle as the weight-commit strobe.
//  Parameters  : BATCH            - samples per update (1..256)
//                HOLD_CYCLES      - cycles backprop is stable before strobe
//                INIT_BATCH_COUNT - value loaded into be_batch_count on reset
//  Ports       : be_clock          - clock, rising edge
//                be_reset_n        - asynchronous active-low reset
//                be_in_valid/ready - sample handshake
//                be_axon/target    - neuron output / desired output
//                be_ratio          - training ratio, sampled at batch close
//                be_flush          - close a partial batch
//                be_backprop       - mean error of the last closed batch
//                be_training_ratio - ratio latched at the last close
//                be_update         - one-cycle commit strobe
//                be_sse            - sum of squared error, last closed batch
//                be_batch_count    - completed batches (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module batch_error_sequencer
    import learning_pkg::*;
#(
    parameter int unsigned BATCH            = C_BATCH_DEFAULT,
    parameter int unsigned HOLD_CYCLES      = C_HOLD_CYCLES_DEFAULT,
    parameter logic [31:0] INIT_BATCH_COUNT = 32'd0
) (
    input  logic        be_clock,
    input  logic        be_reset_n,
    input  logic        be_in_valid,
    output logic        be_in_ready,
    input  real         be_axon,
    input  real         be_target,
    input  real         be_ratio,
    input  logic        be_flush,
    output real         be_backprop,
    output real         be_training_ratio,
    output logic        be_update,
    output real         be_sse,
    output logic [31:0] be_batch_count
);

    be_state_t            state_q;
    be_state_t            state_d;
    logic [C_HOLD_W-1:0]  hold_q;
    logic [C_HOLD_W-1:0]  hold_d;
    logic                 ready_q;
    logic                 update_q;
    real                  backprop_q;
    real                  sse_q;
    real                  ratio_q;
    logic [31:0]          batch_count_q;

    logic                 accept;
    logic                 load;
    logic                 reach;
    logic                 close;
    real                  err;
    real                  acc_nxt;
    real                  sq_nxt;
    logic [C_COUNT_W-1:0] count_nxt;

    assign accept = be_in_valid && ready_q;
    assign err    = be_target - be_axon;
    // The first sample of a batch replaces whatever the previous batch left.
    assign load   = accept && (state_q == BE_IDLE);

    error_accumulator u_acc (
        .clk_i       (be_clock),
        .rst_ni      (be_reset_n),
        .clear_i     (load),
        .add_i       (accept),
        .err_i       (err),
        .acc_nxt_o   (acc_nxt),
        .sq_nxt_o    (sq_nxt),
        .count_nxt_o (count_nxt)
    );

    // A batch closes when the count including this edge's sample reaches
    // BATCH, or on flush while a partial batch is open. Both at once give a
    // single close because they share one condition.
    assign reach = accept && (count_nxt == C_COUNT_W'(BATCH));
    assign close = ((state_q == BE_IDLE) && reach) ||
                   ((state_q == BE_ACCUM) && (reach || be_flush));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            BE_IDLE: begin
                if (close) begin
                    state_d = BE_HOLD;
                    hold_d  = '0;
                end else if (accept) begin
                    state_d = BE_ACCUM;
                end
            end
            BE_ACCUM: begin
                if (close) begin
                    state_d = BE_HOLD;
                    hold_d  = '0;
                end
            end
            BE_HOLD: begin
                if (hold_q == C_HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = BE_STROBE;
                end else begin
                    hold_d = hold_q + C_HOLD_W'(1);
                end
            end
            BE_STROBE: begin
                state_d = BE_IDLE;
            end
            default: begin
                state_d = BE_IDLE;
            end
        endcase
    end

    // Ready and update are registered from the next state so both are low
    // while reset is held and ready rises on the first edge after release.
    always_ff @(posedge be_clock or negedge be_reset_n) begin
        if (!be_reset_n) begin
            state_q       <= BE_IDLE;
            hold_q        <= '0;
            ready_q       <= 1'b0;
            update_q      <= 1'b0;
            backprop_q    <= 0.0;
            sse_q         <= 0.0;
            ratio_q       <= 0.0;
            batch_count_q <= INIT_BATCH_COUNT;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ready_q  <= (state_d == BE_IDLE) || (state_d == BE_ACCUM);
            update_q <= (state_d == BE_STROBE);
            if (close) begin
                backprop_q <= acc_nxt / real'(count_nxt);
                sse_q      <= sq_nxt;
                ratio_q    <= be_ratio;
            end
            if (state_q == BE_STROBE) begin
                batch_count_q <= batch_count_q + 32'd1;
            end
        end
    end

    assign be_in_ready       = ready_q;
    assign be_update         = update_q;
    assign be_backprop       = backprop_q;
    assign be_sse            = sse_q;
    assign be_training_ratio = ratio_q;
    assign be_batch_count    = batch_count_q;

endmodule : batch_error_sequencer
`default_nettype wire

// File: tb/tb_batch_error_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_batch_error_sequencer
//  Description : Self-checking bench. Three instances: BATCH=4, BATCH=1 and
//                BATCH=4 with the batch counter preset to 0xFFFFFFFF. A
//                batch-level model predicts every output each cycle; directed
//                scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_batch_error_sequencer;

    localparam int HOLD = 2;

    function automatic int batch_of(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] init_of(input int k);
        return (k == 2) ? 32'hFFFF_FFFF : 32'd0;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid  [3];
    logic        flush  [3];
    logic        ready  [3];
    logic        upd    [3];
    real         axon   [3];
    real         target [3];
    real         ratio  [3];
    real         bp     [3];
    real         tr     [3];
    real         sse    [3];
    logic [31:0] cnt    [3];

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd [3];
    int n_low [3];

    always #5 clk = ~clk;

    batch_error_sequencer #(.BATCH(4), .HOLD_CYCLES(HOLD), .INIT_BATCH_COUNT(32'd0)) u_b4 (
        .be_clock(clk), .be_reset_n(rst_n), .be_in_valid(valid[0]), .be_in_ready(ready[0]),
        .be_axon(axon[0]), .be_target(target[0]), .be_ratio(ratio[0]), .be_flush(flush[0]),
        .be_backprop(bp[0]), .be_training_ratio(tr[0]), .be_update(upd[0]),
        .be_sse(sse[0]), .be_batch_count(cnt[0]));

    batch_error_sequencer #(.BATCH(1), .HOLD_CYCLES(HOLD), .INIT_BATCH_COUNT(32'd0)) u_b1 (
        .be_clock(clk), .be_reset_n(rst_n), .be_in_valid(valid[1]), .be_in_ready(ready[1]),
        .be_axon(axon[1]), .be_target(target[1]), .be_ratio(ratio[1]), .be_flush(flush[1]),
        .be_backprop(bp[1]), .be_training_ratio(tr[1]), .be_update(upd[1]),
        .be_sse(sse[1]), .be_batch_count(cnt[1]));

    batch_error_sequencer #(.BATCH(4), .HOLD_CYCLES(HOLD), .INIT_BATCH_COUNT(32'hFFFF_FFFF)) u_wrap (
        .be_clock(clk), .be_reset_n(rst_n), .be_in_valid(valid[2]), .be_in_ready(ready[2]),
        .be_axon(axon[2]), .be_target(target[2]), .be_ratio(ratio[2]), .be_flush(flush[2]),
        .be_backprop(bp[2]), .be_training_ratio(tr[2]), .be_update(upd[2]),
        .be_sse(sse[2]), .be_batch_count(cnt[2]));

    // ---------------- batch-level model ----------------
    // Errors are summed per open batch; a close publishes mean/SSE/ratio and
    // starts a busy window of HOLD+1 cycles whose last cycle is the strobe.
    real         m_sum [3];
    real         m_sq  [3];
    real         m_bp  [3];
    real         m_sse [3];
    real         m_tr  [3];
    int          m_n   [3];
    int          m_busy[3];
    logic        m_ready[3];
    logic        m_upd [3];
    logic [31:0] m_cnt [3];

    always @(posedge clk or negedge rst_n) begin
        int  nb;
        real e;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_sum[k] = 0.0; m_sq[k] = 0.0; m_n[k] = 0; m_busy[k] = 0;
                m_bp[k] = 0.0; m_sse[k] = 0.0; m_tr[k] = 0.0;
                m_cnt[k] = init_of(k);
                m_ready[k] = 1'b0;
                m_upd[k] = 1'b0;
            end else begin
                if (m_busy[k] > 0) begin
                    m_busy[k] = m_busy[k] - 1;
                    if (m_busy[k] == 0) m_cnt[k] = m_cnt[k] + 32'd1;
                end else begin
                    nb = m_n[k];
                    if (valid[k] && m_ready[k]) begin
                        e = target[k] - axon[k];
                        m_sum[k] = m_sum[k] + e;
                        m_sq[k]  = m_sq[k] + e * e;
                        m_n[k]   = m_n[k] + 1;
                    end
                    if (m_n[k] == batch_of(k) || (flush[k] && nb > 0)) begin
                        m_bp[k]  = m_sum[k] / m_n[k];
                        m_sse[k] = m_sq[k];
                        m_tr[k]  = ratio[k];
                        m_sum[k] = 0.0; m_sq[k] = 0.0; m_n[k] = 0;
                        m_busy[k] = HOLD + 1;
                    end
                end
                m_ready[k] = (m_busy[k] == 0);
                m_upd[k]   = (m_busy[k] == 1);
            end
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk_bit(input string name, input int k, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%b required=%b t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic chk_real(input string name, input int k, input real act, input real exp);
        real d;
        n_checks++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (d > 1.0e-9) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%f required=%f t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int k, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_bit ("ready",    k, ready[k], m_ready[k]);
            chk_bit ("update",   k, upd[k],   m_upd[k]);
            chk_real("backprop", k, bp[k],    m_bp[k]);
            chk_real("sse",      k, sse[k],   m_sse[k]);
            chk_real("ratio",    k, tr[k],    m_tr[k]);
            chk_int ("count",    k, longint'(cnt[k]), longint'(m_cnt[k]));
            if (rst_n) begin
                if (upd[k] === 1'b1) n_upd[k]++;
                if (ready[k] !== 1'b1) n_low[k]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called and returns at a falling edge; holds the sample until accepted.
    task automatic send(input int k, input real t, input real a, input logic fl);
        int w;
        valid[k] = 1'b1; target[k] = t; axon[k] = a; flush[k] = fl;
        w = 0;
        while (ready[k] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk_bit("send_accept_in_time", k, ready[k], 1'b1);
        @(negedge clk);
        valid[k] = 1'b0; flush[k] = 1'b0;
    endtask

    task automatic pulse_flush(input int k);
        flush[k] = 1'b1;
        @(negedge clk);
        flush[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int w;
        w = 0;
        while (ready[k] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk_bit("idle_in_time", k, ready[k], 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int u0, l0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0; flush[k] = 1'b0;
            axon[k] = 0.0; target[k] = 0.0; ratio[k] = 0.0;
            n_upd[k] = 0; n_low[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit ("reset_ready",  0, ready[0], 1'b0);
        chk_real("reset_bp",     0, bp[0], 0.0);
        chk_int ("reset_preset", 2, longint'(cnt[2]), 64'hFFFF_FFFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("ready_after_release", 0, ready[0], 1'b1);

        // Full batch of four: errors 1, 0.5, -0.5, 0.
        u0 = n_upd[0]; l0 = n_low[0];
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.5, 1'b0);
        send(0, 0.0, 0.5, 1'b0);
        send(0, 1.0, 1.0, 1'b0);
        wait_idle(0);
        chk_real("full_bp",    0, bp[0], 0.25);
        chk_real("full_sse",   0, sse[0], 1.5);
        chk_int ("full_count", 0, longint'(cnt[0]), 1);
        chk_int ("full_pulses",0, n_upd[0] - u0, 1);
        chk_int ("full_low",   0, n_low[0] - l0, 3);

        // Flush while idle is ignored; then errors 2, 2, -1 and a flush.
        u0 = n_upd[0];
        pulse_flush(0);
        repeat (4) @(negedge clk);
        chk_int("idle_flush_pulses", 0, n_upd[0] - u0, 0);
        send(0, 2.0, 0.0, 1'b0);
        send(0, 2.0, 0.0, 1'b0);
        send(0, 0.0, 1.0, 1'b0);
        pulse_flush(0);
        wait_idle(0);
        chk_real("flush_bp",    0, bp[0], 1.0);
        chk_real("flush_sse",   0, sse[0], 9.0);
        chk_int ("flush_count", 0, longint'(cnt[0]), 2);
        chk_int ("flush_pulses",0, n_upd[0] - u0, 1);

        // Sample offered during HOLD/STROBE becomes sample 1 of the next batch.
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 3.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        wait_idle(0);
        chk_real("held_bp",    0, bp[0], 1.5);
        chk_real("held_sse",   0, sse[0], 12.0);
        chk_int ("held_count", 0, longint'(cnt[0]), 4);

        // Reset mid-batch discards the partial accumulation.
        send(0, 5.0, 0.0, 1'b0);
        send(0, 5.0, 0.0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_real("midrst_bp",    0, bp[0], 0.0);
        chk_int ("midrst_count", 0, longint'(cnt[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        u0 = n_upd[0];
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        send(0, 1.0, 0.0, 1'b0);
        wait_idle(0);
        chk_real("postrst_bp",    0, bp[0], 1.0);
        chk_int ("postrst_count", 0, longint'(cnt[0]), 1);
        chk_int ("postrst_pulses",0, n_upd[0] - u0, 1);

        // BATCH=1: ratio latched per sample, held until the next close.
        u0 = n_upd[1];
        ratio[1] = 0.1;
        send(1, 0.5, 0.0, 1'b0);
        wait_idle(1);
        chk_real("b1_ratio_a", 1, tr[1], 0.1);
        chk_real("b1_bp_a",    1, bp[1], 0.5);
        ratio[1] = 0.2;
        @(negedge clk);
        chk_real("b1_ratio_hold", 1, tr[1], 0.1);
        send(1, 0.0, 1.0, 1'b0);
        wait_idle(1);
        chk_real("b1_ratio_b", 1, tr[1], 0.2);
        chk_real("b1_bp_b",    1, bp[1], -1.0);
        chk_int ("b1_count",   1, longint'(cnt[1]), 2);
        chk_int ("b1_pulses",  1, n_upd[1] - u0, 2);

        // Flush with the 4th sample: one close of four; counter wraps.
        u0 = n_upd[2];
        ratio[2] = 0.75;
        send(2, 1.0, 0.0, 1'b0);
        send(2, 1.0, 0.0, 1'b0);
        send(2, 1.0, 0.0, 1'b0);
        send(2, 5.0, 0.0, 1'b1);
        wait_idle(2);
        repeat (6) @(negedge clk);
        chk_real("wrap_bp",    2, bp[2], 2.0);
        chk_real("wrap_sse",   2, sse[2], 28.0);
        chk_real("wrap_ratio", 2, tr[2], 0.75);
        chk_int ("wrap_count", 2, longint'(cnt[2]), 0);
        chk_int ("wrap_pulses",2, n_upd[2] - u0, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_batch_error_sequencer
`default_nettype wire
